// File: rtl/timer_array_if.sv
// Bus interface for the timer array: zero-wait-state register bus with
// strobe/write-enable, word address, and separate read/write data paths.
interface timer_array_if #(
    parameter int AW = 6
);
    logic          STB_I;
    logic          WE_I;
    logic [AW-1:0] ADD_I;
    logic [31:0]   DAT_I;
    logic [31:0]   DAT_O;
    logic          ACK_O;

    modport master (
        output STB_I,
        output WE_I,
        output ADD_I,
        output DAT_I,
        input  DAT_O,
        input  ACK_O
    );

    modport slave (
        input  STB_I,
        input  WE_I,
        input  ADD_I,
        input  DAT_I,
        output DAT_O,
        output ACK_O
    );
endinterface

// File: rtl/timer_array.sv
// Array of NCH independent down-counting timers (one-shot, auto-reload,
// square wave, PWM) with a shared sticky interrupt status/enable pair.
module timer_array #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int AW    = 6
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    timer_array_if.slave     bus,
    output logic [NCH-1:0]   OUT,
    output logic             IRQ_O
);

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_SQUARE  = 2'b10,
        MODE_PWM     = 2'b11
    } mode_t;

    localparam logic [AW-1:0] STAT_ADDR = AW'(4 * NCH);
    localparam logic [AW-1:0] IEN_ADDR  = AW'(4 * NCH + 1);

    logic             wr;
    logic [AW-3:0]    ch_sel;
    logic [1:0]       reg_sel;
    logic             stat_wr;
    logic             ien_wr;

    logic [NCH-1:0]   en;
    logic [1:0]       mode    [NCH];
    logic [WIDTH-1:0] preset  [NCH];
    logic [WIDTH-1:0] count   [NCH];
    logic [WIDTH-1:0] compare [NCH];
    logic [NCH-1:0]   ch_wr;
    logic [NCH-1:0]   terminal;

    logic [NCH-1:0]   irq_stat;
    logic [NCH-1:0]   irq_en;
    logic [NCH-1:0]   stat_clr;
    logic [31:0]      rdata;

    assign wr      = bus.STB_I & bus.WE_I;
    assign ch_sel  = bus.ADD_I[AW-1:2];
    assign reg_sel = bus.ADD_I[1:0];
    assign stat_wr = wr && (bus.ADD_I == STAT_ADDR);
    assign ien_wr  = wr && (bus.ADD_I == IEN_ADDR);

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            logic             en_q;
            mode_t            mode_q;
            logic [WIDTH-1:0] preset_q;
            logic [WIDTH-1:0] count_q;
            logic [WIDTH-1:0] compare_q;
            logic             out_c;

            // Any write to this channel's window freezes its counter for that cycle.
            assign ch_wr[c]    = wr && (ch_sel == (AW-2)'(c));
            assign terminal[c] = en_q && (count_q == '0) && !ch_wr[c];

            always_ff @(posedge CLK_I or negedge RST_I) begin
                if (!RST_I) begin
                    en_q      <= 1'b0;
                    mode_q    <= MODE_ONESHOT;
                    preset_q  <= '0;
                    count_q   <= '0;
                    compare_q <= '0;
                end else if (ch_wr[c]) begin
                    case (reg_sel)
                        2'd0: begin
                            en_q   <= bus.DAT_I[0];
                            mode_q <= mode_t'(bus.DAT_I[2:1]);
                        end
                        2'd1: begin
                            preset_q <= bus.DAT_I[WIDTH-1:0];
                            count_q  <= bus.DAT_I[WIDTH-1:0];
                        end
                        2'd3:    compare_q <= bus.DAT_I[WIDTH-1:0];
                        default: ;
                    endcase
                end else if (en_q) begin
                    if (count_q != '0) begin
                        count_q <= count_q - 1'b1;
                    end else begin
                        case (mode_q)
                            MODE_ONESHOT: en_q    <= 1'b0;
                            MODE_SQUARE:  count_q <= {preset_q[WIDTH-1:1], 1'b0};
                            default:      count_q <= preset_q;
                        endcase
                    end
                end
            end

            // Square reload is even, so the high half (COUNT < PRESET/2) is exact.
            always_comb begin
                out_c = 1'b0;
                case (mode_q)
                    MODE_ONESHOT: out_c = (count_q == '0);
                    MODE_RELOAD:  out_c = (count_q == '0);
                    MODE_SQUARE:  out_c = (count_q < (preset_q >> 1));
                    MODE_PWM:     out_c = (count_q < compare_q);
                    default:      out_c = 1'b0;
                endcase
            end

            assign OUT[c]     = out_c;
            assign en[c]      = en_q;
            assign mode[c]    = mode_q;
            assign preset[c]  = preset_q;
            assign count[c]   = count_q;
            assign compare[c] = compare_q;
        end
    endgenerate

    // A terminal event on the same edge as a write-1-to-clear wins.
    assign stat_clr = stat_wr ? bus.DAT_I[NCH-1:0] : '0;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            irq_stat <= '0;
            irq_en   <= '0;
        end else begin
            irq_stat <= (irq_stat & ~stat_clr) | terminal;
            if (ien_wr) begin
                irq_en <= bus.DAT_I[NCH-1:0];
            end
        end
    end

    assign IRQ_O = |(irq_stat & irq_en);

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == (AW-2)'(i)) begin
                case (reg_sel)
                    2'd0:    rdata = {29'b0, mode[i], en[i]};
                    2'd1:    rdata = 32'(preset[i]);
                    2'd2:    rdata = 32'(count[i]);
                    default: rdata = 32'(compare[i]);
                endcase
            end
        end
        if (bus.ADD_I == STAT_ADDR) begin
            rdata = 32'(irq_stat);
        end
        if (bus.ADD_I == IEN_ADDR) begin
            rdata = 32'(irq_en);
        end
    end

    assign bus.DAT_O = rdata;
    assign bus.ACK_O = bus.STB_I;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: register table first, then hand-written
// sequences for reload, square wave, PWM, isolation and async reset.
module tb_timer_array;
    localparam int NCH   = 4;
    localparam int WIDTH = 32;
    localparam int AW    = 6;

    typedef struct {
        logic          stb;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [31:0]   exp_dat;
        logic [3:0]    exp_out;
        logic          exp_irq;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] out;
    logic           irq;
    int             assertions = 0;
    int             failures = 0;
    vec_t           vecs [23];

    timer_array_if #(.AW(AW)) bus ();

    timer_array #(.NCH(NCH), .WIDTH(WIDTH), .AW(AW)) dut (
        .CLK_I (clk),
        .RST_I (rst_n),
        .bus   (bus.slave),
        .OUT   (out),
        .IRQ_O (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One bus cycle: drive after the falling edge, settle, leave the rising edge to the next call.
    task automatic applyStimulus(input logic stb, input logic we, input logic [AW-1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.STB_I = stb;
        bus.WE_I  = we;
        bus.ADD_I = addr;
        bus.DAT_I = data;
        #1;
    endtask

    task automatic busWrite(input logic [AW-1:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, addr, data);
    endtask

    task automatic idleRead(input logic [AW-1:0] addr);
        applyStimulus(1'b0, 1'b0, addr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi;

        //             stb   we    addr  data          exp_dat       exp_out exp_irq
        vecs[0]  = '{1'b0, 1'b0, 6'd2,  32'h0,        32'd0,        4'hF, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 6'd1,  32'd3,        32'd0,        4'hF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 6'd0,  32'h1,        32'd0,        4'hE, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 6'd2,  32'h0,        32'd3,        4'hE, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 6'd2,  32'h0,        32'd2,        4'hE, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 6'd2,  32'h0,        32'd1,        4'hE, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 6'd2,  32'h0,        32'd0,        4'hF, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 6'd0,  32'h0,        32'd0,        4'hF, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 6'd16, 32'h0,        32'd1,        4'hF, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 6'd17, 32'h1,        32'd0,        4'hF, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 6'd17, 32'h0,        32'd1,        4'hF, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 6'd16, 32'h1,        32'd1,        4'hF, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 6'd16, 32'h0,        32'd0,        4'hF, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 6'd20, 32'hFFFFFFFF, 32'd0,        4'hF, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 6'd17, 32'h0,        32'd1,        4'hF, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 6'd63, 32'h0,        32'd0,        4'hF, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 6'd0,  32'hFFFFFFFE, 32'd0,        4'hF, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 6'd0,  32'h0,        32'd6,        4'hE, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 6'd0,  32'h0,        32'd6,        4'hE, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 6'd0,  32'h0,        32'd0,        4'hF, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 6'd2,  32'd5,        32'd0,        4'hF, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 6'd2,  32'h0,        32'd0,        4'hF, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 6'd1,  32'h0,        32'd3,        4'hF, 1'b0};

        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.ADD_I = '0;
        bus.DAT_I = '0;

        #2;
        checkOutput("reset out", 32'(out), 32'hF);
        checkOutput("reset irq", 32'(irq), 32'h0);
        checkOutput("reset dat", bus.DAT_O, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Register map and one-shot channel 0
        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].stb, vecs[i].we, vecs[i].addr, vecs[i].data);
            checkOutput($sformatf("vec%0d dat", i), bus.DAT_O, vecs[i].exp_dat);
            checkOutput($sformatf("vec%0d out", i), 32'(out), 32'(vecs[i].exp_out));
            checkOutput($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            checkOutput($sformatf("vec%0d ack", i), 32'(bus.ACK_O), 32'(vecs[i].stb));
        end

        // Auto-reload channel 1 with interrupt, clear colliding with terminal event
        busWrite(6'd5, 32'd2);
        busWrite(6'd17, 32'h2);
        busWrite(6'd4, 32'h3);
        idleRead(6'd6);
        checkOutput("rl cnt a", bus.DAT_O, 32'd2);
        checkOutput("rl irq a", 32'(irq), 32'h0);
        idleRead(6'd6);
        checkOutput("rl cnt b", bus.DAT_O, 32'd1);
        idleRead(6'd6);
        checkOutput("rl cnt c", bus.DAT_O, 32'd0);
        checkOutput("rl out1", 32'(out[1]), 32'h1);
        checkOutput("rl irq c", 32'(irq), 32'h0);
        idleRead(6'd6);
        checkOutput("rl cnt d", bus.DAT_O, 32'd2);
        checkOutput("rl irq d", 32'(irq), 32'h1);
        idleRead(6'd6);
        checkOutput("rl cnt e", bus.DAT_O, 32'd1);
        busWrite(6'd16, 32'h2);
        checkOutput("rl stat pre", bus.DAT_O, 32'h2);
        idleRead(6'd16);
        checkOutput("rl set wins", bus.DAT_O, 32'h2);
        checkOutput("rl irq held", 32'(irq), 32'h1);
        busWrite(6'd16, 32'h2);
        idleRead(6'd16);
        checkOutput("rl cleared", bus.DAT_O, 32'h0);
        checkOutput("rl irq low", 32'(irq), 32'h0);
        busWrite(6'd4, 32'h0);
        busWrite(6'd16, 32'h2);

        // Square wave channel 2
        busWrite(6'd9, 32'd9);
        busWrite(6'd8, 32'h5);
        for (int i = 0; i < 10; i++) begin
            idleRead(6'd10);
            checkOutput($sformatf("sq cnt%0d", i), bus.DAT_O, 32'(9 - i));
            checkOutput($sformatf("sq out%0d", i), 32'(out[2]), (9 - i < 4) ? 32'h1 : 32'h0);
        end
        hi = 0;
        for (int i = 0; i < 9; i++) begin
            idleRead(6'd10);
            if (i == 0) checkOutput("sq reload", bus.DAT_O, 32'd8);
            if (out[2]) hi++;
        end
        checkOutput("sq high", 32'(hi), 32'd4);
        idleRead(6'd10);
        checkOutput("sq period", bus.DAT_O, 32'd8);

        // PWM channel 3
        busWrite(6'd13, 32'd9);
        busWrite(6'd15, 32'd3);
        busWrite(6'd12, 32'h7);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            idleRead(6'd14);
            if (i == 0) checkOutput("pwm start", bus.DAT_O, 32'd9);
            if (out[3]) hi++;
        end
        checkOutput("pwm high", 32'(hi), 32'd3);
        idleRead(6'd14);
        checkOutput("pwm period", bus.DAT_O, 32'd9);
        busWrite(6'd15, 32'd0);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            idleRead(6'd14);
            if (out[3]) hi++;
        end
        checkOutput("pwm cmp0", 32'(hi), 32'd0);
        busWrite(6'd15, 32'd20);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            idleRead(6'd14);
            if (out[3]) hi++;
        end
        checkOutput("pwm cmpbig", 32'(hi), 32'd12);

        // Isolation: repeated ch0 writes freeze ch0 only
        busWrite(6'd1, 32'd100);
        busWrite(6'd5, 32'd100);
        busWrite(6'd4, 32'h3);
        for (int i = 0; i < 5; i++) busWrite(6'd0, 32'h1);
        idleRead(6'd2);
        checkOutput("iso ch0", bus.DAT_O, 32'd100);
        idleRead(6'd6);
        checkOutput("iso ch1", bus.DAT_O, 32'd94);
        idleRead(6'd40);
        checkOutput("unmapped", bus.DAT_O, 32'd0);

        // Asynchronous reset mid-operation
        busWrite(6'd17, 32'hF);
        idleRead(6'd2);
        checkOutput("pre rst irq", 32'(irq), 32'h1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst out", 32'(out), 32'hF);
        checkOutput("rst irq", 32'(irq), 32'h0);
        bus.ADD_I = 6'd17;
        #1;
        checkOutput("rst ien", bus.DAT_O, 32'h0);
        bus.ADD_I = 6'd14;
        #1;
        checkOutput("rst cnt3", bus.DAT_O, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idleRead(6'd6);
            checkOutput($sformatf("post rst cnt%0d", i), bus.DAT_O, 32'h0);
            checkOutput($sformatf("post rst out%0d", i), 32'(out), 32'hF);
        end
        idleRead(6'd4);
        checkOutput("post rst ctrl1", bus.DAT_O, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/timer_array.md
TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of independent timer channels (legal 1..8).
REQ-002 SHALL provide parameter WIDTH, default 32, counter/preset/compare width in bits (legal 8..32).
REQ-003 SHALL provide parameter AW, default 6, address width; SHALL satisfy 2^AW >= 4*NCH+2.
REQ-004 CLK_I  input  1  single clock; all state updates on rising edge.
REQ-005 RST_I  input  1  reset, asynchronous, active-low.
REQ-006 STB_I  input  1  bus strobe; cycle valid when high.
REQ-007 WE_I  input  1  write enable; write when STB_I=1 and WE_I=1.
REQ-008 ADD_I  input  AW  word register address.
REQ-009 DAT_I  input  32  write data.
REQ-010 DAT_O  output  32  read data.
REQ-011 ACK_O  output  1  bus acknowledge.
REQ-012 OUT  output  NCH  per-channel timer output.
REQ-013 IRQ_O  output  1  interrupt request, level, active-high.

Function
REQ-014 ACK_O SHALL equal STB_I combinationally (zero wait states); DAT_O SHALL be a combinational decode of ADD_I, valid regardless of STB_I.
REQ-015 Address map: channel c at base 4*c: +0 CTRL, +1 PRESET, +2 COUNT (read-only), +3 COMPARE; 4*NCH IRQ_STAT; 4*NCH+1 IRQ_EN; all other addresses read 0, writes ignored.
REQ-016 CTRL: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 10 square wave, 11 PWM); other bits read 0. WIDTH-bit registers zero-extended on read; DAT_I[WIDTH-1:0] used on write.
REQ-017 Write to PRESET SHALL load PRESET and COUNT with the same value in that cycle; writes to COUNT SHALL be ignored.
REQ-018 Per channel, when EN=1 and no bus write targets that channel this cycle: COUNT!=0 -> COUNT-1; COUNT==0 -> MODE 00: EN<=0, COUNT stays 0; MODE 01/11: COUNT<=PRESET; MODE 10: COUNT<=PRESET with bit0 forced 0.
REQ-019 EN=0: COUNT SHALL hold.
REQ-020 A bus write to any register of channel c SHALL take precedence over counting for channel c only that cycle; other channels SHALL count unaffected.
REQ-021 Terminal event: cycle in which EN=1, COUNT==0 and no write targets the channel; SHALL set IRQ_STAT[c] on that edge.
REQ-022 PRESET=0 in MODE 01/11 SHALL produce a terminal event every enabled cycle.
REQ-023 OUT[c] combinational: MODE 00/01: COUNT==0; MODE 10: COUNT < (PRESET>>1); MODE 11: COUNT < COMPARE (COMPARE=0 -> constant 0; COMPARE>PRESET -> constant 1).
REQ-024 IRQ_STAT[NCH-1:0] write-1-to-clear; simultaneous set and clear of the same bit SHALL leave it set.
REQ-025 IRQ_EN[NCH-1:0] read/write mask; IRQ_O SHALL equal OR of (IRQ_STAT & IRQ_EN), combinational.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; COUNT never decrements below 0 (reload/stop at 0 per REQ-018).

Reset
REQ-027 RST_I low SHALL asynchronously clear CTRL, PRESET, COUNT, COMPARE of every channel, IRQ_STAT and IRQ_EN to 0.
REQ-028 During and after reset: IRQ_O=0, DAT_O per decode of zero registers, OUT=all 1s (MODE 00, COUNT==0).
REQ-029 Reset asserted mid-count SHALL stop all channels immediately; counting resumes only after software re-enables.

Verification
REQ-030 One-shot: ch0 PRESET=3, CTRL=0x1 -> COUNT 3,2,1,0 on successive edges, OUT[0] rises when COUNT=0, next edge EN clears, IRQ_STAT[0]=1.
REQ-031 Auto-reload + IRQ: ch1 PRESET=2, IRQ_EN=0x2, CTRL=0x3 -> COUNT 2,1,0,2,1,0..., IRQ_O high after first 0; write IRQ_STAT=0x2 same cycle as next terminal event -> bit stays 1.
REQ-032 Square wave: ch2 PRESET=9, CTRL=0x5 -> reload value 8, OUT[2] high while COUNT<4, period 9 cycles.
REQ-033 PWM: ch3 PRESET=9, COMPARE=3, CTRL=0x7 -> period 10 cycles, OUT[3] high 3 of 10; COMPARE=0 -> OUT[3] stuck 0.
REQ-034 Isolation: ch0 and ch1 running, write ch0 CTRL every cycle -> ch0 COUNT frozen, ch1 decrements each cycle; unmapped address read -> 0.
REQ-035 Reset mid-operation: all channels enabled, drop RST_I asynchronously -> all registers 0, IRQ_O=0, OUT=all 1s before next clock edge.
